bin_to_bcd_display_feed: RTL and testbench



---
 rtl/bin_to_bcd_display_feed.sv | 128 ++++++++++++
 tb/tb_bin_to_bcd_display_feed.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_display_feed.sv
// bin_to_bcd_display_feed
// Sequential double-dabble converter: unsigned BinIn -> 8 packed BCD digits
// split over NumberB (digits 7..4) and NumberA (digits 3..0). Results are
// registered and held between conversions so a display never sees a partial
// value. Values above 99_999_999 saturate to all nines and raise Ovf.
// Optional feature macro: BCD_AUTO_START_EN -- when defined, any change of
// BinIn while idle starts a conversion without a Start pulse.
module bin_to_bcd_display_feed #(
  parameter int BIN_WIDTH = 27
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [BIN_WIDTH-1:0] BinIn,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Ovf,
  output logic [15:0]          NumberA,
  output logic [15:0]          NumberB
);

  localparam int         SCR_W     = 32 + BIN_WIDTH;
  localparam logic [5:0] LAST_ITER = 6'(BIN_WIDTH - 1);
  localparam logic [63:0] MAX_BCD  = 64'd99_999_999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, next_state;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [5:0]         iter;
  logic               ovf_pend;
  logic               start_req;
  logic               load;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    r = bcd;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Clamp the displayed value to all nines when the input exceeded 8 digits.
  function automatic logic [31:0] bcd_saturate(input logic [31:0] bcd, input logic ovf);
    return ovf ? 32'h9999_9999 : bcd;
  endfunction

  // Width-independent test for an input that cannot fit in 8 BCD digits.
  function automatic logic exceeds_bcd(input logic [BIN_WIDTH-1:0] v);
    logic [63:0] ext;
    ext = 64'(v);
    return ext > MAX_BCD;
  endfunction

`ifdef BCD_AUTO_START_EN
  logic [BIN_WIDTH-1:0] last_bin;

  // Remember the value of each loaded conversion so a change can retrigger.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    last_bin <= '0;
    else if (load) last_bin <= BinIn;
  end

  assign start_req = Start | (BinIn != last_bin);
`else
  assign start_req = Start;
`endif

  assign load        = (state == IDLE) && start_req;
  assign Busy        = (state != IDLE);
  assign scratch_adj = {bcd_adjust(scratch[SCR_W-1:BIN_WIDTH]), scratch[BIN_WIDTH-1:0]};

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: load -> BIN_WIDTH shifts -> one publish cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_req) next_state = SHIFT;
      SHIFT:   if (iter == LAST_ITER) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Iteration counter and overflow flag captured at load time.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      iter     <= '0;
      ovf_pend <= 1'b0;
    end else if (load) begin
      iter     <= '0;
      ovf_pend <= exceeds_bcd(BinIn);
    end else if (state == SHIFT) begin
      iter     <= iter + 6'd1;
    end
  end

  // Double-dabble scratch: BCD field above the binary field, adjust then shift.
  always_ff @(posedge Clk) begin
    if (load)                scratch <= SCR_W'(BinIn);
    else if (state == SHIFT) scratch <= {scratch_adj[SCR_W-2:0], 1'b0};
  end

  // Publish the finished result and pulse Done for one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      NumberA <= '0;
      NumberB <= '0;
      Ovf     <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= (state == DONE);
      if (state == DONE) begin
        {NumberB, NumberA} <= bcd_saturate(scratch[SCR_W-1:BIN_WIDTH], ovf_pend);
        Ovf                <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_display_feed.sv
// Scoreboard bench for bin_to_bcd_display_feed (default BIN_WIDTH = 27).
// Stimulus pushes the hand-computed result {ovf, NumberB, NumberA} into a
// queue; an independent monitor pops and compares on every Done pulse.
module tb_bin_to_bcd_display_feed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] bin_in;
  logic        start;
  logic        busy, done, ovf;
  logic [15:0] number_a, number_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  bin_to_bcd_display_feed #(.BIN_WIDTH(27)) dut (
    .Clk(clk), .Rst_n(rst_n), .BinIn(bin_in), .Start(start),
    .Busy(busy), .Done(done), .Ovf(ovf), .NumberA(number_a), .NumberB(number_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h_%h, required no Done", number_b, number_a);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("number_b", 32'(number_b), 32'(e[31:16]));
        chk("number_a", 32'(number_a), 32'(e[15:0]));
        chk("ovf",      32'(ovf),      32'(e[32]));
      end
    end
  end

  // One conversion with latency and Busy-width checks.
  task automatic run(input logic [26:0] v, input logic use_start, input logic [32:0] e);
    int lat, bcnt;
    @(negedge clk);
    bin_in = v;
    start  = use_start;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("latency",         32'(lat),  32'd28);
    chk("busy_cycles",     32'(bcnt), 32'd28);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_number_a", 32'(number_a), 32'd0);
    chk("rst_number_b", 32'(number_b), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ovf",      32'(ovf),      32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(27'd12_345_678, 1'b1, {1'b0, 16'h1234, 16'h5678});
    run(27'd0,          1'b1, {1'b0, 16'h0000, 16'h0000});
    run(27'd99_999_999, 1'b1, {1'b0, 16'h9999, 16'h9999});
    run(27'd134_217_727, 1'b1, {1'b1, 16'h9999, 16'h9999});
    repeat (5) @(negedge clk);
    chk("ovf_held", 32'(ovf), 32'd1);
    run(27'd42, 1'b1, {1'b0, 16'h0000, 16'h0042});

    // Input change and Start pulse during SHIFT must be ignored.
    @(negedge clk);
    bin_in = 27'd7;
    start  = 1'b1;
    exp_q.push_back({1'b0, 16'h0000, 16'h0007});
`ifdef BCD_AUTO_START_EN
    exp_q.push_back({1'b0, 16'h0000, 16'h0009});
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = 27'd9;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("midrun_done_seen", 32'(done), 32'd1);
    repeat (40) @(negedge clk);
    chk("midrun_idle", 32'(busy), 32'd0);

    // Reset during a conversion wipes the previous result.
    run(27'd5_000, 1'b1, {1'b0, 16'h0000, 16'h5000});
    @(negedge clk);
    bin_in = 27'd77;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_number_a", 32'(number_a), 32'd0);
    chk("abort_number_b", 32'(number_b), 32'd0);
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_done",     32'(done),     32'd0);
    chk("abort_ovf",      32'(ovf),      32'd0);
    @(negedge clk);
`ifdef BCD_AUTO_START_EN
    bin_in = '0;
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_busy", 32'(busy), 32'd0);
    end

    run(27'd1, 1'b1, {1'b0, 16'h0000, 16'h0001});

`ifdef BCD_AUTO_START_EN
    run(27'd0,   1'b1, {1'b0, 16'h0000, 16'h0000});
    run(27'd250, 1'b0, {1'b0, 16'h0000, 16'h0250});
    repeat (40) @(negedge clk);
    chk("auto_idle", 32'(busy), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
